bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Owns the shared memory bus between the CPU and the DMA engine. Implements the BR/BG handshake: drains any in-flight CPU access, grants the bus to the DMA engine, and steers the memory address, control and ready signals to the current owner. Turns the DMA engine's end-of-transfer pulse into a sticky CPU interrupt. Sits between the CPU memory stage, the DMA engine and the memory model.

## Interface
- WORD_SIZE, 16, address width
- TIMEOUT, 64, consecutive granted cycles without a memory beat before fault; 0 disables the watchdog
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- br  in  1  bus request from DMA engine
- bg  out  1  bus grant to DMA engine
- dma_end  in  1  one-cycle end-of-transfer pulse from DMA engine
- dma_addr  in  WORD_SIZE  DMA memory address
- cpu_addr  in  WORD_SIZE  CPU memory address
- cpu_read, cpu_write  in  1 each  CPU memory controls
- cpu_mem_busy  in  1  CPU has an access outstanding
- cpu_bus_hold  out  1  stalls issue of new CPU memory accesses
- mem_signal  in  1  memory ready/beat pulse
- cpu_mem_ready, dma_mem_signal  out  1 each  routed ready pulses
- mem_addr  out  WORD_SIZE; mem_read, mem_write  out  1 each  memory-side bus
- irq_ack  in  1  CPU acknowledge; clears irq_dma and dma_err
- irq_dma  out  1  sticky DMA-complete interrupt
- dma_err  out  1  sticky watchdog fault
- dma_beats  out  WORD_SIZE  beats granted in the current/last DMA tenure

## Operation
- States: CPU_OWN, DRAIN, DMA_OWN, RELEASE, FAULT. Reset → CPU_OWN.
- Moore outputs by state: bg=1 only in DMA_OWN. cpu_bus_hold=1 in DRAIN, DMA_OWN and RELEASE; 0 in CPU_OWN and FAULT.
- CPU_OWN: br=1 → DRAIN; dma_beats cleared to 0 on this transition.
- DRAIN: cpu_mem_busy=0 → DMA_OWN; otherwise stay. br dropping in DRAIN → CPU_OWN.
- DMA_OWN: br=0 → RELEASE; watchdog expiry → FAULT. br=0 takes priority over expiry when both occur in the same cycle.
- RELEASE: one turnaround cycle → CPU_OWN.
- FAULT: br ignored. irq_ack → CPU_OWN; if br is still high, the next cycle restarts the handshake.
- Bus mux:
  - DMA_OWN: mem_addr=dma_addr, mem_read=1, mem_write=0.
  - RELEASE: mem_read=mem_write=0, mem_addr=cpu_addr.
  - Otherwise: CPU signals pass through.
- Ready steering (combinational): dma_mem_signal = mem_signal & (state==DMA_OWN); cpu_mem_ready = mem_signal & (state!=DMA_OWN).
- dma_beats: increments on each mem_signal in DMA_OWN; saturates at all-ones; holds after release.
- Watchdog:
  - Counter cleared on entering DMA_OWN and on every mem_signal in DMA_OWN.
  - Increments on other DMA_OWN cycles; expiry when it reaches TIMEOUT.
  - Counter width $clog2(TIMEOUT+1).
- irq_dma set by dma_end in any state. dma_err set on entry to FAULT. Both cleared by irq_ack; a set event in the same cycle as irq_ack wins.

## Timing
- Reset values: bg=0, cpu_bus_hold=0, irq_dma=0, dma_err=0, dma_beats=0, watchdog=0, mem_read=mem_write=0 unless the CPU drives them.
- Grant latency: br sampled high at edge t.
  - DRAIN is active after t; bg=1 after edge t+1 if cpu_mem_busy=0 in that cycle.
  - Each extra busy cycle adds one cycle of latency.
- Release: br sampled low at edge t → bg=0 after t (RELEASE). CPU owns the bus and cpu_bus_hold=0 after t+1.
- irq_dma rises the cycle after the dma_end pulse and stays high until the cycle after irq_ack.
- Reset mid-tenure: bg drops the cycle after reset is sampled. The DMA engine is responsible for its own recovery.

## Test plan
- Idle CPU: br rises at cycle 10 with cpu_mem_busy=0 → cpu_bus_hold=1 at 11, bg=1 at 12, mem_addr=dma_addr, mem_read=1.
- Drain: br at cycle 10, cpu_mem_busy high through cycle 13 → bg=1 at 15. The CPU's mem_signal during DRAIN appears on cpu_mem_ready, not dma_mem_signal.
- Full transfer: 12 mem_signal beats, then DMA drops br and pulses dma_end → dma_beats=12, bg=0 one cycle later, hold=0 one cycle after that, irq_dma=1 until irq_ack.
- Watchdog: TIMEOUT=4, grant with no mem_signal → FAULT 4 cycles after grant, bg=0, dma_err=1. irq_ack with br high → DRAIN again two cycles later.
- irq_ack coincident with dma_end → irq_dma remains 1. A second irq_ack clears it.
- Reset asserted while in DMA_OWN → all outputs return to reset values next cycle; dma_beats=0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Arbitrates the shared memory bus between the CPU and the DMA engine (BR/BG handshake),
// steers address/control/ready to the owner, counts DMA beats and raises sticky interrupts.
module bus_arbiter #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br,
    output logic                 bg,
    input  logic                 dma_end,
    input  logic [WORD_SIZE-1:0] dma_addr,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic                 cpu_mem_busy,
    output logic                 cpu_bus_hold,
    input  logic                 mem_signal,
    output logic                 cpu_mem_ready,
    output logic                 dma_mem_signal,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic                 irq_ack,
    output logic                 irq_dma,
    output logic                 dma_err,
    output logic [WORD_SIZE-1:0] dma_beats
);

    localparam int unsigned WD_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    // Expiry is flagged on the last idle cycle so FAULT is entered exactly TIMEOUT cycles after grant.
    localparam int unsigned WD_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam bit          WD_EN   = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        CPU_OWN = 3'd0,
        DRAIN   = 3'd1,
        DMA_OWN = 3'd2,
        RELEASE = 3'd3,
        FAULT   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [WORD_SIZE-1:0] beats_q, beats_d;
    logic                 irq_q, irq_d;
    logic                 err_q, err_d;
    logic                 wd_expire_c;

    assign wd_expire_c = WD_EN && (state_q == DMA_OWN) && !mem_signal
                         && (wd_q == WD_W'(WD_LAST));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CPU_OWN;
            wd_q    <= '0;
            beats_q <= '0;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            beats_q <= beats_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; a dropped request outranks watchdog expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            CPU_OWN: if (br) state_d = DRAIN;
            DRAIN: begin
                if (!br)               state_d = CPU_OWN;
                else if (!cpu_mem_busy) state_d = DMA_OWN;
            end
            DMA_OWN: begin
                if (!br)              state_d = RELEASE;
                else if (wd_expire_c) state_d = FAULT;
            end
            RELEASE: state_d = CPU_OWN;
            FAULT:   if (irq_ack) state_d = CPU_OWN;
            default: state_d = CPU_OWN;
        endcase
    end

    // Watchdog, beat counter and sticky interrupt flags; set events win over irq_ack
    always_comb begin
        wd_d    = '0;
        beats_d = beats_q;
        irq_d   = irq_q;
        err_d   = err_q;

        if (WD_EN && (state_q == DMA_OWN) && !mem_signal) wd_d = wd_q + WD_W'(1);

        if ((state_q == CPU_OWN) && (state_d == DRAIN)) begin
            beats_d = '0;
        end else if ((state_q == DMA_OWN) && mem_signal && (beats_q != '1)) begin
            beats_d = beats_q + WORD_SIZE'(1);
        end

        if (irq_ack) irq_d = 1'b0;
        if (dma_end) irq_d = 1'b1;

        if (irq_ack) err_d = 1'b0;
        if ((state_q == DMA_OWN) && (state_d == FAULT)) err_d = 1'b1;
    end

    // Moore outputs, bus mux and ready steering
    always_comb begin
        bg           = 1'b0;
        cpu_bus_hold = 1'b0;
        mem_addr     = cpu_addr;
        mem_read     = cpu_read;
        mem_write    = cpu_write;
        case (state_q)
            DRAIN: cpu_bus_hold = 1'b1;
            DMA_OWN: begin
                bg           = 1'b1;
                cpu_bus_hold = 1'b1;
                mem_addr     = dma_addr;
                mem_read     = 1'b1;
                mem_write    = 1'b0;
            end
            RELEASE: begin
                cpu_bus_hold = 1'b1;
                mem_read     = 1'b0;
                mem_write    = 1'b0;
            end
            default: ;
        endcase
        dma_mem_signal = mem_signal & (state_q == DMA_OWN);
        cpu_mem_ready  = mem_signal & (state_q != DMA_OWN);
    end

    assign irq_dma   = irq_q;
    assign dma_err   = err_q;
    assign dma_beats = beats_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scenario tests plus randomized traffic for bus_arbiter against an ownership-level model.
module tb_bus_arbiter;

    localparam int unsigned WS = 16;
    localparam int          TO = 4;

    logic          clk = 1'b0;
    logic          reset, br, dma_end, cpu_read, cpu_write, cpu_mem_busy, mem_signal, irq_ack;
    logic [WS-1:0] dma_addr, cpu_addr;
    logic          bg, cpu_bus_hold, cpu_mem_ready, dma_mem_signal, mem_read, mem_write;
    logic          irq_dma, dma_err;
    logic [WS-1:0] mem_addr, dma_beats;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter #(.WORD_SIZE(WS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .br(br), .bg(bg), .dma_end(dma_end),
        .dma_addr(dma_addr), .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_mem_busy(cpu_mem_busy), .cpu_bus_hold(cpu_bus_hold), .mem_signal(mem_signal),
        .cpu_mem_ready(cpu_mem_ready), .dma_mem_signal(dma_mem_signal), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_write(mem_write), .irq_ack(irq_ack), .irq_dma(irq_dma),
        .dma_err(dma_err), .dma_beats(dma_beats)
    );

    always #5 clk = ~clk;

    // Ownership model: who holds the bus, how long the DMA has idled, what it has moved
    bit m_drain = 0, m_grant = 0, m_turn = 0, m_fault = 0, m_irq = 0, m_err = 0;
    int m_idle = 0, m_beats = 0;
    bit nx_drain, nx_grant, nx_turn, nx_fault, err_set;

    always @(posedge clk) begin
        if (reset) begin
            m_drain = 0; m_grant = 0; m_turn = 0; m_fault = 0;
            m_idle = 0; m_beats = 0; m_irq = 0; m_err = 0;
        end else begin
            nx_drain = 0; nx_grant = 0; nx_turn = 0; nx_fault = 0; err_set = 0;
            if (!(m_drain || m_grant || m_turn || m_fault) && br) begin
                nx_drain = 1;
                m_beats  = 0;
            end
            if (m_drain && br) begin
                if (cpu_mem_busy) nx_drain = 1;
                else              nx_grant = 1;
            end
            if (m_grant) begin
                if (!br) nx_turn = 1;
                else if (!mem_signal && (m_idle + 1 == TO)) begin nx_fault = 1; err_set = 1; end
                else nx_grant = 1;
                if (mem_signal && m_beats < 65535) m_beats = m_beats + 1;
            end
            m_idle = (m_grant && !mem_signal) ? m_idle + 1 : 0;
            if (m_fault && !irq_ack) nx_fault = 1;
            if (err_set) m_err = 1; else if (irq_ack) m_err = 0;
            if (dma_end) m_irq = 1; else if (irq_ack) m_irq = 0;
            m_drain = nx_drain; m_grant = nx_grant; m_turn = nx_turn; m_fault = nx_fault;
        end
    end

    function automatic logic [39:0] model_vec();
        logic [WS-1:0] a;
        logic rd, wr;
        a  = m_grant ? dma_addr : cpu_addr;
        rd = m_grant ? 1'b1 : (m_turn ? 1'b0 : cpu_read);
        wr = (m_grant || m_turn) ? 1'b0 : cpu_write;
        return {m_grant, (m_drain | m_grant | m_turn), a, rd, wr,
                (mem_signal & m_grant), (mem_signal & ~m_grant), m_irq, m_err, WS'(m_beats)};
    endfunction

    function automatic logic [39:0] dut_vec();
        return {bg, cpu_bus_hold, mem_addr, mem_read, mem_write,
                dma_mem_signal, cpu_mem_ready, irq_dma, dma_err, dma_beats};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        br = 0; dma_end = 0; cpu_read = 0; cpu_write = 0; cpu_mem_busy = 0;
        mem_signal = 0; irq_ack = 0; dma_addr = '0; cpu_addr = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        cpu_read = 1;
        reset = 1;
        step();
        step();
        smp();
        n_checks++;
        if ({bg, cpu_bus_hold, irq_dma, dma_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got bg/hold/irq/err=%b expected 0000",
                     {bg, cpu_bus_hold, irq_dma, dma_err});
        end
        n_checks++;
        if (dma_beats !== 16'd0) begin
            n_fail++; $display("FAIL reset_beats: got %0d expected 0", dma_beats);
        end
        n_checks++;
        if ({mem_read, mem_write} !== 2'b10) begin
            n_fail++; $display("FAIL reset_passthru: got rd/wr=%b expected 10", {mem_read, mem_write});
        end
        reset = 0;
        step();
    endtask

    task automatic test_idle_grant();
        do_reset();
        dma_addr = 16'hA5A0; cpu_addr = 16'h1234; cpu_write = 1;
        br = 1;
        step();
        smp();
        n_checks++;
        if ({cpu_bus_hold, bg} !== 2'b10 || mem_addr !== 16'h1234) begin
            n_fail++;
            $display("FAIL idle_drain: got hold/bg=%b addr=%h expected 10 addr=1234",
                     {cpu_bus_hold, bg}, mem_addr);
        end
        step();
        smp();
        n_checks++;
        if (bg !== 1'b1 || mem_addr !== 16'hA5A0 || {mem_read, mem_write} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_grant: got bg=%b addr=%h rd/wr=%b expected 1 a5a0 10",
                     bg, mem_addr, {mem_read, mem_write});
        end
    endtask

    task automatic test_drain();
        do_reset();
        br = 1; cpu_mem_busy = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            mem_signal = (i == 1);
            smp();
            n_checks++;
            if ({cpu_bus_hold, bg} !== 2'b10) begin
                n_fail++; $display("FAIL drain_hold%0d: got hold/bg=%b expected 10", i, {cpu_bus_hold, bg});
            end
            if (i == 1) begin
                n_checks++;
                if ({cpu_mem_ready, dma_mem_signal} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL drain_ready: got cpu_rdy/dma_sig=%b expected 10",
                             {cpu_mem_ready, dma_mem_signal});
                end
            end
            step();
        end
        cpu_mem_busy = 0; mem_signal = 0;
        smp();
        n_checks++;
        if (bg !== 1'b0) begin
            n_fail++; $display("FAIL drain_last_busy: got bg=%b expected 0", bg);
        end
        step();
        smp();
        n_checks++;
        if (bg !== 1'b1) begin
            n_fail++; $display("FAIL drain_grant: got bg=%b expected 1", bg);
        end
    endtask

    task automatic test_full_transfer();
        do_reset();
        br = 1; cpu_read = 1;
        step();
        step();
        for (int i = 0; i < 24; i++) begin
            mem_signal = (i % 2 == 0);
            dma_addr = WS'(16'h4000 + i);
            step();
        end
        mem_signal = 0; br = 0; dma_end = 1;
        step();
        dma_end = 0;
        smp();
        n_checks++;
        if (dma_beats !== 16'd12) begin
            n_fail++; $display("FAIL xfer_beats: got %0d expected 12", dma_beats);
        end
        n_checks++;
        if ({bg, cpu_bus_hold, mem_read, irq_dma} !== 4'b0101) begin
            n_fail++;
            $display("FAIL xfer_release: got bg/hold/rd/irq=%b expected 0101",
                     {bg, cpu_bus_hold, mem_read, irq_dma});
        end
        step();
        smp();
        n_checks++;
        if ({cpu_bus_hold, mem_read, irq_dma} !== 3'b011 || dma_beats !== 16'd12) begin
            n_fail++;
            $display("FAIL xfer_cpu_back: got hold/rd/irq=%b beats=%0d expected 011 12",
                     {cpu_bus_hold, mem_read, irq_dma}, dma_beats);
        end
        irq_ack = 1;
        step();
        irq_ack = 0;
        smp();
        n_checks++;
        if (irq_dma !== 1'b0) begin
            n_fail++; $display("FAIL xfer_irq_ack: got irq=%b expected 0", irq_dma);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        br = 1;
        step();
        step();
        for (int i = 0; i < TO; i++) begin
            smp();
            n_checks++;
            if (bg !== 1'b1) begin
                n_fail++; $display("FAIL wd_granted%0d: got bg=%b expected 1", i, bg);
            end
            step();
        end
        smp();
        n_checks++;
        if ({bg, cpu_bus_hold, dma_err} !== 3'b001) begin
            n_fail++;
            $display("FAIL wd_fault: got bg/hold/err=%b expected 001", {bg, cpu_bus_hold, dma_err});
        end
        irq_ack = 1;
        step();
        irq_ack = 0;
        smp();
        n_checks++;
        if ({cpu_bus_hold, dma_err} !== 2'b00) begin
            n_fail++; $display("FAIL wd_ack: got hold/err=%b expected 00", {cpu_bus_hold, dma_err});
        end
        step();
        smp();
        n_checks++;
        if ({cpu_bus_hold, bg} !== 2'b10) begin
            n_fail++; $display("FAIL wd_rearb: got hold/bg=%b expected 10", {cpu_bus_hold, bg});
        end
    endtask

    task automatic test_irq_coincident();
        do_reset();
        dma_end = 1;
        step();
        dma_end = 0;
        smp();
        n_checks++;
        if (irq_dma !== 1'b1) begin
            n_fail++; $display("FAIL irq_set: got %b expected 1", irq_dma);
        end
        dma_end = 1; irq_ack = 1;
        step();
        dma_end = 0; irq_ack = 0;
        smp();
        n_checks++;
        if (irq_dma !== 1'b1) begin
            n_fail++; $display("FAIL irq_coincident: got %b expected 1", irq_dma);
        end
        irq_ack = 1;
        step();
        irq_ack = 0;
        smp();
        n_checks++;
        if (irq_dma !== 1'b0) begin
            n_fail++; $display("FAIL irq_second_ack: got %b expected 0", irq_dma);
        end
    endtask

    task automatic test_reset_mid_tenure();
        do_reset();
        br = 1;
        step();
        step();
        mem_signal = 1;
        step();
        step();
        mem_signal = 0;
        smp();
        n_checks++;
        if (bg !== 1'b1 || dma_beats !== 16'd2) begin
            n_fail++; $display("FAIL midrst_pre: got bg=%b beats=%0d expected 1 2", bg, dma_beats);
        end
        reset = 1;
        step();
        smp();
        n_checks++;
        if ({bg, cpu_bus_hold, irq_dma, dma_err} !== 4'b0000 || dma_beats !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_post: got bg/hold/irq/err=%b beats=%0d expected 0000 0",
                     {bg, cpu_bus_hold, irq_dma, dma_err}, dma_beats);
        end
        reset = 0;
        clear_inputs();
        step();
    endtask

    task automatic test_random();
        logic [39:0] got, exp;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) br = ~br;
            reset        = ($urandom_range(0, 149) == 0);
            cpu_mem_busy = ($urandom_range(0, 9) < 4);
            mem_signal   = ($urandom_range(0, 9) < 4);
            dma_end      = ($urandom_range(0, 19) == 0);
            irq_ack      = ($urandom_range(0, 9) == 0);
            cpu_read     = 1'($urandom);
            cpu_write    = 1'($urandom);
            dma_addr     = WS'($urandom);
            cpu_addr     = WS'($urandom);
            smp();
            got = dut_vec();
            exp = model_vec();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", c, got, exp);
            end
            step();
        end
        reset = 0;
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        step();
        test_reset();
        test_idle_grant();
        test_drain();
        test_full_transfer();
        test_watchdog();
        test_irq_coincident();
        test_reset_mid_tenure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
